// File: rtl/ula_multiciclo_if.sv
// Operand/result bundle between the ALU controller and the multi-cycle ALU.
// Master drives the request (inicio, cod_ula, a, b); slave returns result and status.
interface ula_multiciclo_if #(
    parameter int LARGURA = 32
);
    logic               inicio;
    logic [3:0]         cod_ula;
    logic [LARGURA-1:0] a;
    logic [LARGURA-1:0] b;
    logic [LARGURA-1:0] resultado;
    logic               zero;
    logic               valido;
    logic               ocupado;
    logic               erro;

    modport master (
        output inicio, cod_ula, a, b,
        input  resultado, zero, valido, ocupado, erro
    );

    modport slave (
        input  inicio, cod_ula, a, b,
        output resultado, zero, valido, ocupado, erro
    );
endinterface

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: AND/OR/ADD/SUB/SLT in 1 edge, shift-add MUL in LARGURA+1 edges.
// No backpressure: requests are dropped while ocupado=1; valido is a one-cycle pulse.
module ula_multiciclo #(
    parameter int LARGURA = 32
) (
    input  logic               clk,
    input  logic               rst,
    ula_multiciclo_if.slave    bus
);
    localparam int CW = $clog2(LARGURA + 1);

    localparam logic [3:0] COD_AND = 4'b0000;
    localparam logic [3:0] COD_OR  = 4'b0001;
    localparam logic [3:0] COD_ADD = 4'b0010;
    localparam logic [3:0] COD_SUB = 4'b0110;
    localparam logic [3:0] COD_SLT = 4'b0111;
    localparam logic [3:0] COD_MUL = 4'b1000;

    typedef enum logic {
        OCIOSO     = 1'b0,
        MULTIPLICA = 1'b1
    } estado_t;

    estado_t            estado;
    estado_t            prox_estado;

    logic [LARGURA-1:0] res_reg;
    logic               zero_reg;
    logic               valido_reg;
    logic               erro_reg;

    logic [LARGURA-1:0] multiplicando;
    logic [LARGURA-1:0] multiplicador;
    logic [LARGURA-1:0] acumulador;
    logic [CW-1:0]      contador;

    logic [LARGURA-1:0] res_simples;
    logic               suportado;
    logic [LARGURA-1:0] acum_prox;
    logic               aceita;
    logic               ultima_iter;

    // Single-cycle operations; unsupported codes yield zero with suportado low.
    always_comb begin
        res_simples = '0;
        suportado   = 1'b1;
        case (bus.cod_ula)
            COD_AND: res_simples = bus.a & bus.b;
            COD_OR:  res_simples = bus.a | bus.b;
            COD_ADD: res_simples = bus.a + bus.b;
            COD_SUB: res_simples = bus.a - bus.b;
            COD_SLT: res_simples = ($signed(bus.a) < $signed(bus.b)) ? LARGURA'(1) : '0;
            COD_MUL: res_simples = '0;
            default: suportado   = 1'b0;
        endcase
    end

    assign acum_prox   = acumulador + (multiplicador[0] ? multiplicando : '0);
    assign aceita      = (estado == OCIOSO) && bus.inicio;
    assign ultima_iter = (estado == MULTIPLICA) && (contador == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:     if (bus.inicio && bus.cod_ula == COD_MUL) prox_estado = MULTIPLICA;
            MULTIPLICA: if (contador == CW'(1)) prox_estado = OCIOSO;
            default:    prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg       <= '0;
            zero_reg      <= 1'b1;
            valido_reg    <= 1'b0;
            erro_reg      <= 1'b0;
            multiplicando <= '0;
            multiplicador <= '0;
            acumulador    <= '0;
            contador      <= '0;
        end else begin
            valido_reg <= 1'b0;
            if (aceita) begin
                if (bus.cod_ula == COD_MUL) begin
                    multiplicando <= bus.a;
                    multiplicador <= bus.b;
                    acumulador    <= '0;
                    contador      <= CW'(LARGURA);
                end else begin
                    res_reg    <= res_simples;
                    zero_reg   <= (res_simples == '0);
                    erro_reg   <= ~suportado;
                    valido_reg <= 1'b1;
                end
            end else if (estado == MULTIPLICA) begin
                acumulador    <= acum_prox;
                multiplicando <= multiplicando << 1;
                multiplicador <= multiplicador >> 1;
                contador      <= contador - CW'(1);
                // The last iteration's sum goes straight to the result register.
                if (ultima_iter) begin
                    res_reg    <= acum_prox;
                    zero_reg   <= (acum_prox == '0);
                    erro_reg   <= 1'b0;
                    valido_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.resultado = res_reg;
    assign bus.zero      = zero_reg;
    assign bus.valido    = valido_reg;
    assign bus.erro      = erro_reg;
    assign bus.ocupado   = (estado == MULTIPLICA);
endmodule
